// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, word/step constants.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0033;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/if_slot.sv
// One-entry IF/ID output register with valid/ready handshake and flush.
module if_slot
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    input  logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    // Flush wins over a refill; a consumed entry with no refill simply drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: byte PC and IDLE/RUN/HALT control, word-indexed IMEM port,
// registered IF/ID slot, redirect handling and sticky fault flag.
module inst_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            busy,
    output logic            err,
    output logic [XLEN-1:0] fetch_count
);

    state_t          state;
    logic [XLEN-1:0] pc;

    logic accept;
    logic slot_free;
    logic redirect_hit;
    logic redirect_bad;
    logic in_range;
    logic fetch_try;
    logic do_load;
    logic fault;

    assign imem_pc = pc >> 2;
    assign busy    = (state == RUN);

    assign accept       = out_valid && out_ready;
    assign slot_free    = !out_valid || out_ready;
    assign redirect_hit = redirect_valid && (state != IDLE);
    assign redirect_bad = redirect_hit && (redirect_pc[1:0] != 2'b00);
    assign in_range     = imem_pc < XLEN'(IMEM_DEPTH);

    // A fetch is attempted only when the slot can take it; the range check
    // applies to that attempt, so a stalled slot never raises a fault.
    assign fetch_try = (state == RUN) && !redirect_hit && slot_free;
    assign do_load   = fetch_try && in_range;
    assign fault     = fetch_try && !in_range;

    if_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_hit),
        .load      (do_load),
        .load_inst (imem_inst),
        .load_pc   (pc),
        .ready     (out_ready),
        .valid     (out_valid),
        .inst      (out_inst),
        .pc        (out_pc)
    );

    // Redirect outranks fetch, halt_req and start; err only ever clears on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            err         <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (accept)
                fetch_count <= fetch_count + 1'b1;

            if (redirect_hit) begin
                if (redirect_bad) begin
                    err   <= 1'b1;
                    state <= HALT;
                end else begin
                    pc <= redirect_pc;
                    if (state == RUN && halt_req)
                        state <= HALT;
                    else if (state == HALT && start && !err)
                        state <= RUN;
                end
            end else begin
                case (state)
                    IDLE: if (start) state <= RUN;
                    RUN: begin
                        if (fault) begin
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            if (do_load)
                                pc <= pc + PC_STEP;
                            if (halt_req)
                                state <= HALT;
                        end
                    end
                    HALT: if (start && !err) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that drives the word-indexed instruction memory and delivers instructions to decode.
- Holds the byte PC and sends the word index (pc >> 2) to the combinational IMEM read port.
- Registers the returned instruction into an IF/ID output slot with a valid/ready handshake.
- Handles start, halt, redirect (branch/jump) and address faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- IMEM_DEPTH, 10, number of 32-bit words in the instruction memory; word index >= IMEM_DEPTH is a fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; IDLE/HALT -> RUN.
- halt_req  in  1  stop issuing new fetches.
- redirect_valid  in  1  PC redirect request from execute.
- redirect_pc  in  32  byte target address.
- imem_pc  out  32  word index to IMEM (pc >> 2), combinational from the pc register.
- imem_inst  in  32  instruction word from IMEM, same cycle.
- out_valid  out  1  IF/ID slot holds an instruction.
- out_ready  in  1  decode accepts the slot this cycle.
- out_inst  out  32  registered instruction.
- out_pc  out  32  byte PC of out_inst.
- busy  out  1  state == RUN.
- err  out  1  sticky fault flag: misaligned redirect or out-of-range fetch.
- fetch_count  out  32  number of instructions handed to decode (out_valid && out_ready).

Behaviour:
- Reset is asynchronous and takes effect immediately. On reset:
  - state = IDLE, pc = RESET_PC;
  - out_valid = 0, out_inst = 0, out_pc = 0;
  - err = 0, fetch_count = 0, busy = 0.
- FSM states: IDLE, RUN, HALT.
  - IDLE: no fetch. start -> RUN.
  - RUN: fetch as below.
    - halt_req -> HALT (takes effect next cycle).
    - Fault -> HALT with err = 1.
  - HALT: no new fetch. A pending out_valid is held until accepted.
    - start with err = 0 -> RUN, resuming at the current pc.
    - start with err = 1 is ignored; only rst clears err.
- slot_free = !out_valid || out_ready.
- Fetch in RUN with slot_free and no redirect:
  - out_inst <= imem_inst, out_pc <= pc, out_valid <= 1;
  - pc <= pc + 4, modulo 2^32 (wraps, no fault from the wrap itself).
  - Latency: pc to out_valid is 1 cycle. Throughput is 1 instruction per cycle while out_ready = 1.
- Backpressure: out_valid = 1 and out_ready = 0 holds pc, out_inst and out_pc unchanged. No fetch occurs.
- Consumption without refill (IDLE/HALT, or out-of-range fault): out_ready with out_valid sets out_valid <= 0.
- Redirect (RUN or HALT) has priority over fetch and halt_req in the same cycle:
  - pc <= redirect_pc, out_valid <= 0 (flush); the same-cycle fetch is discarded.
  - fetch_count still increments if out_valid && out_ready that cycle.
  - redirect_pc[1:0] != 0: pc is unchanged, err <= 1, state -> HALT.
  - halt_req in the same cycle: the redirect is applied, then state -> HALT.
- Out-of-range: in RUN, if (pc >> 2) >= IMEM_DEPTH:
  - no slot load, err <= 1, state -> HALT;
  - imem_inst is ignored that cycle.
- fetch_count increments on every out_valid && out_ready, in any state, and wraps at 2^32.
- imem_pc is valid in every state. IMEM is combinational and has no enable.

Decomposition:
- Shared package rv_pkg holds:
  - the FSM state encoding (IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2);
  - the NOP constant 32'h0000_0033;
  - XLEN = 32;
  - PC_STEP = 4.
- Natural sub-module: if_slot (one-entry valid/ready output register with flush). The PC/FSM logic stays in inst_fetch.

Test Plan:
- Reset then start with out_ready = 1 and IMEM words 0..2 = add instructions -> out_pc = 0, 4, 8 on consecutive cycles, each matching its word; fetch_count = 3 after the third accept.
- Hold out_ready = 0 for 3 cycles after the first valid -> out_inst/out_pc stay at word 0/pc 0 and imem_pc stays 1; release -> word 1 follows with no loss or duplicate.
- Redirect to 0x14 while out_valid = 1 -> next cycle out_valid = 0; the following cycle out_pc = 0x14 with inst = word 5.
- Redirect to 0x06 -> err = 1, busy = 0, pc unchanged; a later start is ignored.
- RESET_PC = 0x20 with IMEM_DEPTH = 10 -> words 8 and 9 delivered, then pc = 0x28 faults: err = 1, HALT, no third valid.
- Assert rst mid-stream with out_valid = 1 -> outputs clear immediately (asynchronously); after release state = IDLE and pc = RESET_PC.
